// File: rtl/dac_play_sequencer.sv
// dac_play_sequencer
//   Click-free start/stop sequencer for the sigma-delta DAC output path.
//   Every start, stop and source change follows the same order: mute
//   (soft ramp or hard), modulator flush, source switch, gain ramp-up.
//   Lock loss is a hard mute; stream loss, source change and host mute
//   ramp the gain down first.
//
// Ports
//   clk          system clock (1024fs domain)
//   rst          synchronous active-high reset
//   fs_stb_i     one-cycle strobe per sample period
//   pcm_valid_i  PCM sample strobe from the I2S receiver
//   dsd_req_i    asynchronous DSD-mode request pin
//   lock_i       asynchronous PLL lock
//   mute_req_i   host mute bit (clk domain)
//   gain_o       PCM gain to the modulator input multiplier
//   dsm_rst_o    modulator integrator reset
//   mode_dsd_o   output mux select (1 = DSD)
//   dsd_en_o     DSD bitstream gate
//   state_o      current state (0 MUTED, 1 FLUSH, 2 UNMUTE, 3 RUN, 4 MUTE)
//   mute_evt_o   count of entries into MUTE, wraps 255 to 0
module dac_play_sequencer #(
  parameter int GAIN_W      = 16,
  parameter int RAMP_STEP   = 4096,
  parameter int FLUSH_FS    = 32,
  parameter int PCM_TIMEOUT = 64,
  parameter int DEB_FS      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs_stb_i,
  input  logic              pcm_valid_i,
  input  logic              dsd_req_i,
  input  logic              lock_i,
  input  logic              mute_req_i,
  output logic [GAIN_W-1:0] gain_o,
  output logic              dsm_rst_o,
  output logic              mode_dsd_o,
  output logic              dsd_en_o,
  output logic [2:0]        state_o,
  output logic [7:0]        mute_evt_o
);

  localparam int WD_W  = $clog2(PCM_TIMEOUT + 1);
  localparam int FL_W  = $clog2(FLUSH_FS + 1);
  localparam int DEB_W = $clog2(DEB_FS + 1);

  localparam logic [GAIN_W-1:0] GAIN_MAX  = {GAIN_W{1'b1}};
  localparam logic [GAIN_W-1:0] STEP_G    = GAIN_W'(RAMP_STEP);
  localparam logic [GAIN_W:0]   STEP_WIDE = (GAIN_W + 1)'(RAMP_STEP);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(PCM_TIMEOUT);
  localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(FLUSH_FS - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_FS - 1);

  typedef enum logic [2:0] {
    ST_MUTED  = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_UNMUTE = 3'd2,
    ST_RUN    = 3'd3,
    ST_MUTE   = 3'd4
  } state_t;

  state_t            state_q, state_n;
  logic [GAIN_W-1:0] gain_n;
  logic              mode_n;
  logic [7:0]        evt_n;
  logic [FL_W-1:0]   flush_q, flush_n;

  logic              lock_s1, lock_s2;
  logic              dsd_s1, dsd_s2;
  logic              dsd_acc;
  logic [DEB_W-1:0]  deb_q;
  logic [WD_W-1:0]   wd_q;
  logic              pcm_alive;
  logic              stop;

  logic [GAIN_W:0]   gain_sum;
  logic [GAIN_W-1:0] gain_up;
  logic [GAIN_W-1:0] gain_dn;

  // Two-flop synchronisers for the asynchronous pins
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      dsd_s1  <= 1'b0;
      dsd_s2  <= 1'b0;
    end else begin
      lock_s1 <= lock_i;
      lock_s2 <= lock_s1;
      dsd_s1  <= dsd_req_i;
      dsd_s2  <= dsd_s1;
    end
  end

  // DSD request debounce: the count only advances while the synced pin
  // disagrees with the accepted value; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dsd_acc <= 1'b0;
      deb_q   <= '0;
    end else if (dsd_s2 == dsd_acc) begin
      deb_q <= '0;
    end else if (fs_stb_i) begin
      if (deb_q == DEB_LAST) begin
        dsd_acc <= dsd_s2;
        deb_q   <= '0;
      end else begin
        deb_q <= deb_q + 1'b1;
      end
    end
  end

  // PCM watchdog; a sample strobe beats a coincident fs strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= WD_LIMIT;
    end else if (pcm_valid_i) begin
      wd_q <= '0;
    end else if (fs_stb_i && (wd_q < WD_LIMIT)) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign pcm_alive = (wd_q < WD_LIMIT);
  assign stop      = mute_req_i | (dsd_acc != mode_dsd_o) | (!mode_dsd_o & !pcm_alive);

  // Saturating ramp arithmetic, one extra bit to catch overflow
  assign gain_sum = {1'b0, gain_o} + STEP_WIDE;
  assign gain_up  = (gain_sum > {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_sum[GAIN_W-1:0];
  assign gain_dn  = (gain_o > STEP_G) ? (gain_o - STEP_G) : '0;

  // Next-state logic. Lock loss overrides everything as a hard mute.
  // Transitions never apply a gain step in the same cycle.
  always_comb begin
    state_n = state_q;
    gain_n  = gain_o;
    mode_n  = mode_dsd_o;
    evt_n   = mute_evt_o;
    flush_n = flush_q;
    if (!lock_s2) begin
      state_n = ST_MUTED;
      gain_n  = '0;
    end else begin
      case (state_q)
        ST_MUTED: begin
          gain_n  = '0;
          flush_n = '0;
          if (!mute_req_i && (dsd_acc || pcm_alive)) begin
            state_n = ST_FLUSH;
            mode_n  = dsd_acc;
          end
        end
        ST_FLUSH: begin
          gain_n = '0;
          if (stop) begin
            state_n = ST_MUTED;
          end else if (fs_stb_i) begin
            if (flush_q == FL_LAST) begin
              state_n = ST_UNMUTE;
            end else begin
              flush_n = flush_q + 1'b1;
            end
          end
        end
        ST_UNMUTE: begin
          if (stop) begin
            state_n = ST_MUTE;
            evt_n   = mute_evt_o + 8'd1;
          end else if (gain_o == GAIN_MAX) begin
            state_n = ST_RUN;
          end else if (fs_stb_i) begin
            gain_n = gain_up;
          end
        end
        ST_RUN: begin
          gain_n = GAIN_MAX;
          if (stop) begin
            state_n = ST_MUTE;
            evt_n   = mute_evt_o + 8'd1;
          end
        end
        ST_MUTE: begin
          // Committed ramp-down: a clearing stop condition does not reverse it
          if (gain_o == '0) begin
            state_n = ST_MUTED;
          end else if (fs_stb_i) begin
            gain_n = gain_dn;
          end
        end
        default: begin
          state_n = ST_MUTED;
          gain_n  = '0;
        end
      endcase
    end
  end

  // State and registered outputs; the gates follow the next state so
  // they change together with state_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_MUTED;
      gain_o     <= '0;
      mode_dsd_o <= 1'b0;
      mute_evt_o <= 8'd0;
      flush_q    <= '0;
      dsm_rst_o  <= 1'b1;
      dsd_en_o   <= 1'b0;
    end else begin
      state_q    <= state_n;
      gain_o     <= gain_n;
      mode_dsd_o <= mode_n;
      mute_evt_o <= evt_n;
      flush_q    <= flush_n;
      dsm_rst_o  <= (state_n == ST_MUTED);
      dsd_en_o   <= (state_n == ST_RUN) && mode_n;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_dac_play_sequencer.sv
// tb_dac_play_sequencer
//   Directed scenarios plus a randomized phase for dac_play_sequencer.
//   A cycle-level behavioural model built from the sequencing rules is
//   compared against every output on every cycle, and directed steps add
//   fixed expectations for ramp lengths, timeouts and counters.
module tb_dac_play_sequencer;

  localparam int FS_DIV      = 4;
  localparam int GAIN_MAX    = 65535;
  localparam int STEP        = 4096;
  localparam int FLUSH_FS    = 32;
  localparam int PCM_TIMEOUT = 64;
  localparam int DEB_FS      = 4;

  localparam int S_MUTED  = 0;
  localparam int S_FLUSH  = 1;
  localparam int S_UNMUTE = 2;
  localparam int S_RUN    = 3;
  localparam int S_MUTE   = 4;

  logic        clk;
  logic        rst;
  logic        fs_stb_i;
  logic        pcm_valid_i;
  logic        dsd_req_i;
  logic        lock_i;
  logic        mute_req_i;
  logic [15:0] gain_o;
  logic        dsm_rst_o;
  logic        mode_dsd_o;
  logic        dsd_en_o;
  logic [2:0]  state_o;
  logic [7:0]  mute_evt_o;

  dac_play_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .fs_stb_i    (fs_stb_i),
    .pcm_valid_i (pcm_valid_i),
    .dsd_req_i   (dsd_req_i),
    .lock_i      (lock_i),
    .mute_req_i  (mute_req_i),
    .gain_o      (gain_o),
    .dsm_rst_o   (dsm_rst_o),
    .mode_dsd_o  (mode_dsd_o),
    .dsd_en_o    (dsd_en_o),
    .state_o     (state_o),
    .mute_evt_o  (mute_evt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus shaping
  int phase    = 0;
  int pv_phase = 0;
  bit pcm_on   = 1'b1;
  bit pv_fixed = 1'b0;

  // observation counters
  int fs_seen       = 0;
  int flush_strobes = 0;
  int ramp_up       = 0;
  int ramp_dn       = 0;

  // reference model
  int m_state, m_gain, m_mode, m_evt, m_dsm, m_dsd_en;
  int m_flush, m_lk1, m_lk2, m_ds1, m_ds2, m_acc, m_deb, m_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    int lock_seen;
    int dsd_seen;
    int acc_old;
    bit alive;
    bit stop;
    if (rst) begin
      m_state = S_MUTED; m_gain = 0; m_mode = 0; m_evt = 0; m_flush = 0;
      m_lk1 = 0; m_lk2 = 0; m_ds1 = 0; m_ds2 = 0;
      m_acc = 0; m_deb = 0; m_wd = PCM_TIMEOUT;
    end else begin
      lock_seen = m_lk2;
      dsd_seen  = m_ds2;
      acc_old   = m_acc;
      alive     = (m_wd < PCM_TIMEOUT);
      stop      = mute_req_i || (acc_old != m_mode) || (m_mode == 0 && !alive);
      m_lk2 = m_lk1; m_lk1 = int'(lock_i);
      m_ds2 = m_ds1; m_ds1 = int'(dsd_req_i);
      if (dsd_seen == m_acc) m_deb = 0;
      else if (fs_stb_i) begin
        m_deb++;
        if (m_deb == DEB_FS) begin
          m_acc = dsd_seen;
          m_deb = 0;
        end
      end
      if (pcm_valid_i) m_wd = 0;
      else if (fs_stb_i && m_wd < PCM_TIMEOUT) m_wd++;
      if (lock_seen == 0) begin
        m_state = S_MUTED;
        m_gain  = 0;
      end else begin
        case (m_state)
          S_MUTED: begin
            m_gain = 0; m_flush = 0;
            if (!mute_req_i && (acc_old == 1 || alive)) begin
              m_state = S_FLUSH;
              m_mode  = acc_old;
            end
          end
          S_FLUSH: begin
            if (stop) m_state = S_MUTED;
            else if (fs_stb_i) begin
              m_flush++;
              if (m_flush == FLUSH_FS) m_state = S_UNMUTE;
            end
          end
          S_UNMUTE: begin
            if (stop) begin
              m_state = S_MUTE;
              m_evt   = (m_evt + 1) % 256;
            end else if (m_gain == GAIN_MAX) m_state = S_RUN;
            else if (fs_stb_i) m_gain = (m_gain + STEP > GAIN_MAX) ? GAIN_MAX : m_gain + STEP;
          end
          S_RUN: begin
            m_gain = GAIN_MAX;
            if (stop) begin
              m_state = S_MUTE;
              m_evt   = (m_evt + 1) % 256;
            end
          end
          default: begin
            if (m_gain == 0) m_state = S_MUTED;
            else if (fs_stb_i) m_gain = (m_gain < STEP) ? 0 : m_gain - STEP;
          end
        endcase
      end
    end
    m_dsm    = (m_state == S_MUTED) ? 1 : 0;
    m_dsd_en = (m_state == S_RUN && m_mode == 1) ? 1 : 0;
  endtask

  task automatic checkOutput();
    chk("state", 32'(state_o), 32'(m_state));
    chk("gain", 32'(gain_o), 32'(m_gain));
    chk("dsm_rst", 32'(dsm_rst_o), 32'(m_dsm));
    chk("mode_dsd", 32'(mode_dsd_o), 32'(m_mode));
    chk("dsd_en", 32'(dsd_en_o), 32'(m_dsd_en));
    chk("mute_evt", 32'(mute_evt_o), 32'(m_evt));
  endtask

  // One clock cycle: derive strobes, clock, advance the model, compare
  task automatic applyStimulus();
    logic [2:0]  pre_state;
    logic [15:0] pre_gain;
    logic        pre_fs;
    fs_stb_i    = (phase == FS_DIV - 1);
    pcm_valid_i = pcm_on && (pv_fixed ? (phase == FS_DIV - 1) : (phase == pv_phase));
    pre_state   = state_o;
    pre_gain    = gain_o;
    pre_fs      = fs_stb_i;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    if (pre_fs) fs_seen++;
    if (pre_fs && pre_state == 3'(S_FLUSH)) flush_strobes++;
    if (state_o == 3'(S_UNMUTE) && gain_o > pre_gain) ramp_up++;
    if (state_o == 3'(S_MUTE) && gain_o < pre_gain) ramp_dn++;
    if (phase == FS_DIV - 1) begin
      phase    = 0;
      pv_phase = $urandom_range(0, FS_DIV - 1);
    end else begin
      phase++;
    end
  endtask

  task automatic runFs(input int n);
    int target;
    target = fs_seen + n;
    while (fs_seen < target) applyStimulus();
  endtask

  task automatic waitState(input int target, input int max_cycles, input string tag);
    int k;
    k = 0;
    while (state_o !== 3'(target) && k < max_cycles) begin
      applyStimulus();
      k++;
    end
    chk(tag, 32'(state_o), 32'(target));
  endtask

  initial begin
    int base;
    int k;
    rst = 1'b1; fs_stb_i = 1'b0; pcm_valid_i = 1'b0;
    dsd_req_i = 1'b0; lock_i = 1'b1; mute_req_i = 1'b0;

    // reset values
    repeat (2) applyStimulus();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_gain", 32'(gain_o), 0);
    chk("rst_dsm_rst", 32'(dsm_rst_o), 1);
    chk("rst_mute_evt", 32'(mute_evt_o), 0);

    // start-up: flush then ramp up to PCM RUN
    rst = 1'b0;
    flush_strobes = 0; ramp_up = 0;
    waitState(S_RUN, 400, "s1_run");
    chk("s1_flush_strobes", 32'(flush_strobes), 32);
    chk("s1_ramp_up_steps", 32'(ramp_up), 16);
    chk("s1_gain_full", 32'(gain_o), 65535);
    chk("s1_mode_pcm", 32'(mode_dsd_o), 0);

    // host mute: ramp down, then replay the start-up
    ramp_dn = 0;
    mute_req_i = 1'b1;
    waitState(S_MUTED, 200, "s2_muted");
    chk("s2_ramp_dn_steps", 32'(ramp_dn), 16);
    chk("s2_mute_evt", 32'(mute_evt_o), 1);
    chk("s2_dsm_rst", 32'(dsm_rst_o), 1);
    mute_req_i = 1'b0;
    flush_strobes = 0; ramp_up = 0;
    waitState(S_RUN, 400, "s2_rerun");
    chk("s2_flush_strobes", 32'(flush_strobes), 32);
    chk("s2_ramp_up_steps", 32'(ramp_up), 16);

    // DSD request: 3-strobe glitch ignored, held request switches source
    runFs(1);
    dsd_req_i = 1'b1;
    runFs(3);
    dsd_req_i = 1'b0;
    runFs(4);
    chk("s3_glitch_state", 32'(state_o), 32'(S_RUN));
    chk("s3_glitch_mode", 32'(mode_dsd_o), 0);
    dsd_req_i = 1'b1;
    waitState(S_MUTED, 200, "s3_muted");
    waitState(S_RUN, 500, "s3_run_dsd");
    chk("s3_mode_dsd", 32'(mode_dsd_o), 1);
    chk("s3_dsd_en", 32'(dsd_en_o), 1);
    dsd_req_i = 1'b0;
    waitState(S_MUTED, 200, "s3_muted_back");
    waitState(S_RUN, 500, "s3_run_pcm");
    chk("s3_mode_back", 32'(mode_dsd_o), 0);
    chk("s3_dsd_en_off", 32'(dsd_en_o), 0);

    // PCM stream loss: timeout after 64 strobes, ramp-down not reversed
    pv_fixed = 1'b1;
    runFs(2);
    pcm_on = 1'b0;
    base = fs_seen;
    waitState(S_MUTE, 400, "s4_mute");
    chk("s4_timeout_strobes", 32'(fs_seen - base), 64);
    chk("s4_mute_evt", 32'(mute_evt_o), 4);
    pv_fixed = 1'b0;
    runFs(4);
    pcm_on = 1'b1;
    waitState(S_MUTED, 200, "s4_ramp_completes");
    chk("s4_gain_zero", 32'(gain_o), 0);
    waitState(S_RUN, 500, "s4_rerun");

    // lock loss mid-ramp: hard mute three cycles after the pin drops
    mute_req_i = 1'b1;
    waitState(S_MUTED, 200, "s5_muted");
    mute_req_i = 1'b0;
    k = 0;
    while (!(state_o == 3'(S_UNMUTE) && gain_o == 16'd32768) && k < 400) begin
      applyStimulus();
      k++;
    end
    chk("s5_reach_half", 32'(gain_o), 32768);
    lock_i = 1'b0;
    repeat (2) applyStimulus();
    chk("s5_sync_delay_state", 32'(state_o), 32'(S_UNMUTE));
    applyStimulus();
    chk("s5_lock_state", 32'(state_o), 32'(S_MUTED));
    chk("s5_lock_gain", 32'(gain_o), 0);
    chk("s5_lock_evt", 32'(mute_evt_o), 5);
    lock_i = 1'b1;
    waitState(S_RUN, 500, "s5_rerun");

    // watchdog at 63 with coincident valid and fs: no stop
    pv_fixed = 1'b1;
    runFs(2);
    pcm_on = 1'b0;
    runFs(63);
    pcm_on = 1'b1;
    runFs(5);
    chk("s6_no_stop_state", 32'(state_o), 32'(S_RUN));
    chk("s6_no_stop_evt", 32'(mute_evt_o), 5);
    pv_fixed = 1'b0;

    // synchronous reset mid-UNMUTE
    mute_req_i = 1'b1;
    waitState(S_MUTED, 200, "s7_muted");
    mute_req_i = 1'b0;
    waitState(S_UNMUTE, 300, "s7_unmute");
    runFs(3);
    rst = 1'b1;
    applyStimulus();
    chk("s7_rst_state", 32'(state_o), 0);
    chk("s7_rst_gain", 32'(gain_o), 0);
    chk("s7_rst_dsm_rst", 32'(dsm_rst_o), 1);
    chk("s7_rst_mode", 32'(mode_dsd_o), 0);
    chk("s7_rst_dsd_en", 32'(dsd_en_o), 0);
    chk("s7_rst_evt", 32'(mute_evt_o), 0);
    rst = 1'b0;
    waitState(S_RUN, 500, "s7_rerun");

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (phase == 0) begin
        if ($urandom_range(0, 99) < 3)  mute_req_i = ~mute_req_i;
        if ($urandom_range(0, 99) < 3)  dsd_req_i  = ~dsd_req_i;
        if ($urandom_range(0, 99) < 2)  pcm_on     = ~pcm_on;
        if (lock_i && $urandom_range(0, 99) < 1) lock_i = 1'b0;
        else if (!lock_i && $urandom_range(0, 99) < 30) lock_i = 1'b1;
      end
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
